// File: rtl/frame_loader.sv
// frame_loader: framebuffer writer for the HUB75 scanner.
// Takes the UART byte stream, waits for a sync byte, then assembles
// R,G,B byte triples into pixel words and writes them into the upper-half
// bank (wr_en1, scanner data1) or lower-half bank (wr_en2, scanner data2).
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   rx_data/rx_valid  received byte and its single-cycle strobe
//   wr_addr           bank write address (same encoding as the scanner)
//   wr_data           pixel {B,G,R}, bitdepth bits per channel
//   wr_en1/wr_en2     one-cycle write strobes, upper/lower bank
//   frame_done        one-cycle pulse with the write of the last pixel
//   frame_err         one-cycle pulse when a frame aborts on timeout
module frame_loader #(
  parameter int         length    = 5,
  parameter int         bitdepth  = 8,
  parameter int         scan_bit  = 3,
  parameter int         timeout   = 1000,
  parameter logic [7:0] sync_byte = 8'hA5
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [7:0]                                rx_data,
  input  logic                                      rx_valid,
  output logic [$clog2(length*(1<<scan_bit))-1:0]   wr_addr,
  output logic [3*bitdepth-1:0]                     wr_data,
  output logic                                      wr_en1,
  output logic                                      wr_en2,
  output logic                                      frame_done,
  output logic                                      frame_err
);

  localparam int HALF = length * (1 << scan_bit);
  localparam int NPIX = 2 * HALF;
  localparam int AW   = $clog2(HALF);
  localparam int PW   = $clog2(NPIX);
  localparam int CW   = $clog2(timeout + 1);

  localparam logic [PW-1:0] PIX_LAST = PW'(NPIX - 1);
  localparam logic [PW-1:0] PIX_HALF = PW'(HALF);
  localparam logic [CW-1:0] CNT_LAST = CW'(timeout - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RED,
    S_GREEN,
    S_BLUE
  } state_t;

  state_t                  state_q, state_d;
  logic [PW-1:0]           pix_q, pix_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [bitdepth-1:0]     r_q, r_d;
  logic [bitdepth-1:0]     g_q, g_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic [3*bitdepth-1:0]   data_q, data_d;
  logic                    en1_q, en1_d;
  logic                    en2_q, en2_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [bitdepth-1:0]     chan;

  // Reduced-depth channels keep the MSBs of the received byte.
  assign chan = rx_data[7 -: bitdepth];

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    g_d     = g_q;
    addr_d  = addr_q;
    data_d  = data_q;
    en1_d   = 1'b0;
    en2_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (state_q == S_IDLE) begin
      cnt_d = '0;
      if (rx_valid && (rx_data == sync_byte)) begin
        pix_d   = '0;
        state_d = S_RED;
      end
    end else if (rx_valid) begin
      // A byte on the expiry cycle still counts: rx_valid is tested first.
      cnt_d = '0;
      case (state_q)
        S_RED: begin
          r_d     = chan;
          state_d = S_GREEN;
        end
        S_GREEN: begin
          g_d     = chan;
          state_d = S_BLUE;
        end
        default: begin
          data_d = {chan, g_q, r_q};
          if (pix_q < PIX_HALF) begin
            en1_d  = 1'b1;
            addr_d = AW'(pix_q);
          end else begin
            en2_d  = 1'b1;
            addr_d = AW'(pix_q - PIX_HALF);
          end
          if (pix_q == PIX_LAST) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            pix_d   = pix_q + 1'b1;
            state_d = S_RED;
          end
        end
      endcase
    end else if (cnt_q == CNT_LAST) begin
      // This idle cycle is the timeout-th one since the last byte.
      cnt_d   = '0;
      err_d   = 1'b1;
      state_d = S_IDLE;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pix_q   <= '0;
      cnt_q   <= '0;
      r_q     <= '0;
      g_q     <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      en1_q   <= 1'b0;
      en2_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      g_q     <= g_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      en1_q   <= en1_d;
      en2_q   <= en2_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign wr_addr    = addr_q;
  assign wr_data    = data_q;
  assign wr_en1     = en1_q;
  assign wr_en2     = en2_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;

endmodule
